// File: rtl/dmem_access_ctrl_if.sv
// Port bundles for the data-memory access controller: the core-side memory
// port and the word-RAM request/acknowledge port.

interface dmem_core_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;

    // master = pipeline core, slave = access controller
    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        input  mem_din, mem_stall
    );
    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        output mem_din, mem_stall
    );
endinterface

interface dmem_ram_if #(
    parameter int ADDR_W = 10
);
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_ack;

    // master = access controller, slave = word RAM
    modport master (
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_rdata, ram_ack
    );
    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_rdata, ram_ack
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Turns the core's single-cycle memory port into a req/ack transaction on a
// variable-latency word RAM, stalling the core until the result is ready.

module dmem_access_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    dmem_core_if.slave  core,
    dmem_ram_if.master  ram,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  WAIT_LAST    = 8'(TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    state_t            state_reg;
    state_t            state_next;

    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rd_reg;
    logic [7:0]        wait_cnt_reg;
    logic              err_misalign_reg;
    logic              err_timeout_reg;
    logic [31:0]       stall_cnt_reg;

    logic              acc;
    logic              aligned;
    logic              start;
    logic              misalign_hit;
    logic              timeout_hit;
    logic              stall;

    // Only the word-address slice of the byte address reaches the RAM.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^core.mem_addr[31:ADDR_W+2];

    assign acc          = core.mem_ren | core.mem_wen;
    assign aligned      = (core.mem_addr[1:0] == 2'b00);
    assign start        = (state_reg == ST_IDLE) & acc & aligned;
    assign misalign_hit = (state_reg == ST_IDLE) & acc & ~aligned;
    // A late ack on the final wait cycle still wins over the timeout.
    assign timeout_hit  = (state_reg == ST_REQ) & ~ram.ram_ack &
                          (wait_cnt_reg == WAIT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ram.ram_ack || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        stall         = 1'b0;
        ram.ram_req   = 1'b0;
        core.mem_din  = 32'h0;
        case (state_reg)
            ST_IDLE: begin
                stall = start;
            end
            ST_REQ: begin
                stall       = 1'b1;
                ram.ram_req = 1'b1;
            end
            ST_DONE: begin
                core.mem_din = rd_reg;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign core.mem_stall = stall;
    assign ram.ram_we     = we_reg;
    assign ram.ram_addr   = addr_reg;
    assign ram.ram_wdata  = wdata_reg;
    assign err_misalign   = err_misalign_reg;
    assign err_timeout    = err_timeout_reg;
    assign stall_cnt      = stall_cnt_reg;

    // ---------------- request latch ----------------
    // Captured once when the access is accepted, then held for the whole REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 32'h0;
        end else if (start) begin
            we_reg    <= core.mem_wen;
            addr_reg  <= core.mem_addr[ADDR_W+1:2];
            wdata_reg <= core.mem_dout;
        end
    end

    // ---------------- wait counter and read register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= 8'h0;
            rd_reg       <= 32'h0;
        end else if (start) begin
            wait_cnt_reg <= 8'h0;
        end else if (state_reg == ST_REQ) begin
            if (ram.ram_ack) begin
                if (!we_reg) begin
                    rd_reg <= ram.ram_rdata;
                end
            end else if (timeout_hit) begin
                rd_reg <= TIMEOUT_DATA;
            end else begin
                wait_cnt_reg <= wait_cnt_reg + 8'h1;
            end
        end
    end

    // ---------------- sticky error flags ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_misalign_reg <= 1'b0;
            err_timeout_reg  <= 1'b0;
        end else begin
            if (misalign_hit) begin
                err_misalign_reg <= 1'b1;
            end
            if (timeout_hit) begin
                err_timeout_reg <= 1'b1;
            end
        end
    end

    // ---------------- debug stall counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= 32'h0;
        end else if (stall) begin
            stall_cnt_reg <= stall_cnt_reg + 32'h1;
        end
    end

    // ---------------- structural checks ----------------
    a_state_legal: assert property (@(posedge clk) disable iff (rst)
        state_reg != 2'd3);

    a_done_one_cycle: assert property (@(posedge clk) disable iff (rst)
        (state_reg == ST_DONE) |=> (state_reg == ST_IDLE));

endmodule
